sgc_window_feeder: RTL and testbench
====================================

Name: sgc_window_feeder

Overview:
- Streaming front end for the sgc smoothing filter.
- Accepts one signed sample per valid/ready handshake into a sliding window of WINDOW_SIZE samples.
- Presents each complete window to the combinational filter through a valid/ready handshake.
- Throttles the input stream when the downstream stage stalls, so every window position from a continuous sample stream is presented exactly once.

Parameters:
- WINDOW_SIZE, 7, samples per window; legal range 3..15.
- DATA_W, 32, sample width in bits (signed).
- CNT_W, 16, width of the window sequence counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  feeder can accept a sample this cycle.
- s_data  in  DATA_W  signed input sample.
- flush  in  1  synchronous clear of window contents and fill count.
- win_valid  out  1  win_data holds a complete, unconsumed window.
- win_ready  in  1  downstream consumes the window this cycle.
- win_data  out  WINDOW_SIZE*DATA_W  flattened window. Slot k is at bits [k*DATA_W +: DATA_W]. Slot 0 is the oldest sample; slot WINDOW_SIZE-1 is the newest. Slot k maps to data_window[k].
- fill_count  out  4  valid samples held, 0..WINDOW_SIZE.
- win_seq  out  CNT_W  number of windows consumed since reset/flush; wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FILL; all window slots 0; fill_count=0; win_valid=0; win_seq=0.
  - s_ready=0 while rst_n is low; s_ready=1 in the first cycle after release.
- Accept event: s_valid && s_ready at a rising edge.
  - All slots shift down by one: slot k <= slot k+1.
  - slot WINDOW_SIZE-1 <= s_data.
  - fill_count increments, saturating at WINDOW_SIZE.
- Consume event: win_valid && win_ready at a rising edge; win_seq increments.
- States:
  - FILL: fill_count < WINDOW_SIZE; s_ready=1; win_valid=0. An accept that brings fill_count to WINDOW_SIZE moves to PEND.
  - PEND: win_valid=1; s_ready=win_ready (combinational pass-through).
    - Consume without accept -> DONE.
    - Consume with simultaneous accept -> stay in PEND; the shifted window is valid on the next cycle. This is full throughput: one window per cycle.
    - No consume -> stay in PEND; win_data and win_valid are held stable.
  - DONE: win_valid=0; s_ready=1. An accept moves to PEND.
- Latency: a sample accepted at edge N appears in win_data, and win_valid (when the window is complete) asserts, after edge N, i.e. one cycle.
- win_data and win_valid are registered outputs; there is no combinational path from s_data to win_data.
- Once asserted, win_valid must not drop and win_data must not change until a consume event or flush.
- flush (synchronous, highest priority):
  - Next state FILL; fill_count=0; win_valid=0; win_seq=0.
  - Slots are cleared to 0.
  - Any accept or consume in the same cycle is discarded; win_seq is not incremented.
- s_ready is 0 in a flush cycle.
- Reset mid-window discards everything; no partial window is ever presented.
- Samples are stored unmodified (signed two's complement); no arithmetic is performed on data.
- win_seq wraps from 2^CNT_W-1 to 0 without any flag.

Decomposition:
- Package sgc_pkg holds:
  - the state enum typedef (FILL, PEND, DONE);
  - default constants SGC_WINDOW_SIZE=7 and SGC_DATA_W=32, shared with the sgc filter;
  - a slot index helper function.
- Sub-module sgc_shift_window is natural: parameterised shift register with enable and clear, flattened output.
- The FSM, counters and handshake stay in sgc_window_feeder.

Test Plan:
- Fill: reset, then push samples 1..7 with s_valid held high and win_ready=0.
  - win_valid rises the cycle after the 7th accept; win_data slots = 1,2,3,4,5,6,7; fill_count=7.
  - s_ready=0 thereafter.
- Stall hold: after the fill, hold win_ready=0 for 5 cycles with s_valid=1, s_data=8.
  - win_data unchanged; no accept occurs; win_seq=0.
- Full throughput: after the fill, assert win_ready=1 and stream 8..12.
  - Windows [2..8], [3..9], ..., [6..12] appear on consecutive cycles; win_seq=5 after the last consume.
- Drain: consume window [1..7] with s_valid=0.
  - Next cycle win_valid=0 and state is DONE.
  - Push 8: window [2..8] is valid one cycle later.
- Flush: pulse flush together with s_valid=1 and win_ready=1 while in PEND.
  - fill_count=0, win_valid=0, win_seq=0; the concurrent sample is not stored.
  - 7 new pushes are needed before win_valid rises.
- Async reset: drop rst_n mid-edge after 4 samples, with no clock running.
  - Outputs clear immediately.
  - After release, signed samples -5,-4,...,1 produce window slots -5..1 exactly (sign preserved).

Source files
------------

// File: rtl/sgc_pkg.sv
// Shared definitions for the sgc smoothing filter front end.
//   - sgc_state_t : feeder FSM states
//   - SGC_WINDOW_SIZE / SGC_DATA_W : default geometry shared with the filter
//   - slot_lsb()  : bit offset of a window slot in the flattened window bus
package sgc_pkg;

    localparam int SGC_WINDOW_SIZE = 7;
    localparam int SGC_DATA_W      = 32;

    typedef enum logic [1:0] {
        FILL = 2'd0,   // collecting the first WINDOW_SIZE samples
        PEND = 2'd1,   // complete window presented, waiting for consume
        DONE = 2'd2    // window consumed, waiting for the next sample
    } sgc_state_t;

    // Slot k of a flattened window sits at bits [k*data_w +: data_w].
    function automatic int slot_lsb(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/sgc_window_feeder_if.sv
// Handshake bundle between the sample source, the feeder and the filter.
//   s_valid/s_ready/s_data       : sample stream into the feeder
//   win_valid/win_ready/win_data : window stream out to the filter
// slave  : the feeder side
// master : the environment side (source and filter together)
interface sgc_window_feeder_if
    import sgc_pkg::*;
#(
    parameter int WINDOW_SIZE = SGC_WINDOW_SIZE,
    parameter int DATA_W      = SGC_DATA_W
);
    logic                          s_valid;
    logic                          s_ready;
    logic signed [DATA_W-1:0]      s_data;
    logic                          win_valid;
    logic                          win_ready;
    logic [WINDOW_SIZE*DATA_W-1:0] win_data;

    modport slave (
        input  s_valid, s_data, win_ready,
        output s_ready, win_valid, win_data
    );

    modport master (
        output s_valid, s_data, win_ready,
        input  s_ready, win_valid, win_data
    );
endinterface

// File: rtl/sgc_shift_window.sv
// Parameterised sliding window shift register.
//   clk, rst_n : clock, async active-low reset (clears all slots)
//   clr        : synchronous clear, wins over en
//   en         : shift one position toward slot 0, din enters slot DEPTH-1
//   din        : new sample
//   dout       : flattened window, slot 0 (oldest) in the low bits
module sgc_shift_window
    import sgc_pkg::*;
#(
    parameter int DEPTH  = SGC_WINDOW_SIZE,
    parameter int DATA_W = SGC_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [DATA_W-1:0]       din,
    output logic [DEPTH*DATA_W-1:0] dout
);
    logic [DEPTH-1:0][DATA_W-1:0] slots;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots <= '0;
        end else if (clr) begin
            slots <= '0;
        end else if (en) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                slots[k] <= slots[k+1];
            end
            slots[DEPTH-1] <= din;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        localparam int LSB = slot_lsb(k, DATA_W);
        assign dout[LSB +: DATA_W] = slots[k];
    end
endmodule

// File: rtl/sgc_window_feeder.sv
// Streaming front end for the sgc smoothing filter.
// Collects signed samples into a sliding window and presents each complete
// window once; the input is throttled while a window waits to be consumed.
//   clk, rst_n  : clock, async active-low reset
//   bus         : sample and window handshakes (slave side)
//   flush       : synchronous clear of window, fill count and sequence count
//   fill_count  : samples held, saturating at WINDOW_SIZE
//   win_seq     : windows consumed since reset/flush, wraps silently
module sgc_window_feeder
    import sgc_pkg::*;
#(
    parameter int WINDOW_SIZE = SGC_WINDOW_SIZE,
    parameter int DATA_W      = SGC_DATA_W,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sgc_window_feeder_if.slave bus,
    input  logic               flush,
    output logic [3:0]         fill_count,
    output logic [CNT_W-1:0]   win_seq
);
    localparam logic [3:0] FULL = 4'(WINDOW_SIZE);

    sgc_state_t                    state;
    logic                          win_valid_q;
    logic                          s_ready_c;
    logic                          accept;
    logic                          consume;
    logic [WINDOW_SIZE*DATA_W-1:0] window;

    // In PEND a new sample may only enter when the current window leaves in
    // the same cycle, so ready passes straight through from the consumer.
    // Gating with rst_n keeps the source stalled while reset is held.
    always_comb begin
        s_ready_c = 1'b1;
        if (state == PEND) s_ready_c = bus.win_ready;
        if (flush || !rst_n) s_ready_c = 1'b0;
    end

    assign accept  = bus.s_valid && s_ready_c;
    assign consume = win_valid_q && bus.win_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            fill_count  <= '0;
            win_valid_q <= 1'b0;
            win_seq     <= '0;
        end else if (flush) begin
            state       <= FILL;
            fill_count  <= '0;
            win_valid_q <= 1'b0;
            win_seq     <= '0;
        end else begin
            if (consume) win_seq <= win_seq + CNT_W'(1);
            if (accept && fill_count != FULL) fill_count <= fill_count + 4'd1;
            case (state)
                FILL: begin
                    if (accept && fill_count == FULL - 4'd1) begin
                        state       <= PEND;
                        win_valid_q <= 1'b1;
                    end
                end
                PEND: begin
                    // accept implies consume here; only a bare consume drains
                    if (consume && !accept) begin
                        state       <= DONE;
                        win_valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state       <= PEND;
                        win_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= FILL;
                    win_valid_q <= 1'b0;
                end
            endcase
        end
    end

    sgc_shift_window #(
        .DEPTH  (WINDOW_SIZE),
        .DATA_W (DATA_W)
    ) u_window (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (accept),
        .din   (bus.s_data),
        .dout  (window)
    );

    assign bus.s_ready   = s_ready_c;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = window;
endmodule

// File: tb/tb_sgc_window_feeder.sv
module tb_sgc_window_feeder;
    import sgc_pkg::*;

    localparam int W  = SGC_WINDOW_SIZE;
    localparam int DW = SGC_DATA_W;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst_n  = 1'b0;
    logic        flush  = 1'b0;
    logic [3:0]  fill_count;
    logic [15:0] win_seq;

    int n_chk  = 0;
    int n_fail = 0;

    sgc_window_feeder_if #(.WINDOW_SIZE(W), .DATA_W(DW)) bus ();

    sgc_window_feeder #(.WINDOW_SIZE(W), .DATA_W(DW), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .fill_count (fill_count),
        .win_seq    (win_seq)
    );

    // Clock can be frozen (low) to exercise the asynchronous reset.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic        sv;
        int          sd;
        logic        wr;
        logic        fl;
        logic        e_rdy;   // s_ready before the edge
        logic        e_wv;    // after the edge
        int          e_fill;
        int          e_seq;
        int          e_s0;    // oldest slot
        int          e_sl;    // newest slot
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sv, int sd, logic wr, logic fl, logic e_rdy,
                                logic e_wv, int e_fill, int e_seq, int e_s0, int e_sl);
        vec_t v;
        v.sv = sv; v.sd = sd; v.wr = wr; v.fl = fl; v.e_rdy = e_rdy;
        v.e_wv = e_wv; v.e_fill = e_fill; v.e_seq = e_seq; v.e_s0 = e_s0; v.e_sl = e_sl;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int slot(input int k);
        return $signed(bus.win_data[k*DW +: DW]);
    endfunction

    task automatic drive(input logic sv, input int sd, input logic wr, input logic fl);
        bus.s_valid   = sv;
        bus.s_data    = sd;
        bus.win_ready = wr;
        flush         = fl;
    endtask

    initial begin
        drive(1'b0, 0, 1'b0, 1'b0);

        // ---- reset state ----
        #12;
        chk("rst.s_ready", bus.s_ready, 0);
        chk("rst.win_valid", bus.win_valid, 0);
        chk("rst.fill", fill_count, 0);
        chk("rst.seq", win_seq, 0);
        chk("rst.data", (bus.win_data == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel.s_ready", bus.s_ready, 1);

        // ---- table: fill, stall, throughput, drain, DONE push, flush, refill ----
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(1, i, 0, 0, 1, i == 7, i, 0, (i == 7) ? 1 : 0, i));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 8, 0, 0, 0, 1, 7, 0, 1, 7));
        for (int i = 8; i <= 12; i++)
            vecs.push_back(mk(1, i, 1, 0, 1, 1, 7, i - 7, i - 6, i));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 7, 6, 6, 12));     // drain -> DONE
        vecs.push_back(mk(1, 13, 0, 0, 1, 1, 7, 6, 7, 13));    // DONE push -> PEND
        vecs.push_back(mk(1, 14, 1, 1, 0, 0, 0, 0, 0, 0));     // flush wins
        for (int i = 1; i <= 7; i++)
            vecs.push_back(mk(1, 20 + i, 0, 0, 1, i == 7, i, 0, (i == 7) ? 21 : 0, 20 + i));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].sv, vecs[i].sd, vecs[i].wr, vecs[i].fl);
            #1 chk($sformatf("v%0d.s_ready", i), bus.s_ready, vecs[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.win_valid", i), bus.win_valid, vecs[i].e_wv);
            chk($sformatf("v%0d.fill", i), fill_count, vecs[i].e_fill);
            chk($sformatf("v%0d.seq", i), win_seq, vecs[i].e_seq);
            chk($sformatf("v%0d.slot0", i), slot(0), vecs[i].e_s0);
            chk($sformatf("v%0d.slotN", i), slot(W - 1), vecs[i].e_sl);
        end
        // full window after refill: 21..27
        for (int k = 0; k < W; k++) chk($sformatf("refill.slot%0d", k), slot(k), 21 + k);

        // ---- drain of the very first window, then push one sample ----
        @(negedge clk);
        drive(1'b0, 0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("drain.win_valid", bus.win_valid, 0);
        chk("drain.state", dut.state, DONE);
        chk("drain.seq", win_seq, 1);
        @(negedge clk);
        drive(1'b1, 28, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("push28.win_valid", bus.win_valid, 1);
        for (int k = 0; k < W; k++) chk($sformatf("push28.slot%0d", k), slot(k), 22 + k);

        // ---- async reset with the clock stopped ----
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst.win_valid", bus.win_valid, 0);
        chk("arst.fill", fill_count, 0);
        chk("arst.seq", win_seq, 0);
        chk("arst.s_ready", bus.s_ready, 0);
        chk("arst.data", (bus.win_data == '0), 1);
        #5 rst_n = 1'b1;
        #1 chk("arst.rel_s_ready", bus.s_ready, 1);
        clk_en = 1'b1;

        // signed samples -5..1
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            drive(1'b1, i - 5, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("neg.win_valid", bus.win_valid, 1);
        chk("neg.fill", fill_count, 7);
        for (int k = 0; k < W; k++) chk($sformatf("neg.slot%0d", k), slot(k), k - 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
